// File: rtl/ctrl_sequencer.sv
// Stateful control decoder: instruction decode, multi-word register load, memory-wait stalls, sticky halt.
// Optional feature macro: CTRL_PERF_CNT_EN adds perf_instr / perf_stall counters.
module ctrl_sequencer #(
    parameter int unsigned IW          = 9,
    parameter int unsigned LOAD_WORDS  = 1,
    parameter int unsigned MEM_LAT     = 0,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [IW-1:0] Instruction,
    input  logic          instr_valid,
    input  logic          mem_ready,
    output logic          Immediate,
    output logic          RegSet,
    output logic          BranchEn,
    output logic          ConditionBranch,
    output logic          Halt,
    output logic          Shift,
    output logic          RDX,
    output logic          MemToReg,
    output logic          RegWriteEn,
    output logic          MemWriteEn,
    output logic          Inc,
    output logic          LoadWord,
    output logic [3:0]    LoadIdx,
    output logic          Stall,
    output logic          Halted,
    output logic          MemErr
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]   perf_instr,
    output logic [31:0]   perf_stall
`endif
);

    localparam int unsigned WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0]  OPC_LOAD  = 3'b000;
    localparam logic [2:0]  OPC_STORE = 3'b001;
    localparam logic [2:0]  OPC_ADD   = 3'b010;
    localparam logic [2:0]  OPC_SUB   = 3'b011;
    localparam logic [2:0]  OPC_XOR   = 3'b100;
    localparam logic [2:0]  OPC_CMP   = 3'b101;
    localparam logic [2:0]  OPC_LSH   = 3'b110;
    localparam logic [2:0]  OPC_BR    = 3'b111;
    localparam logic [3:0]  LOAD_LAST = 4'(LOAD_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit          MEM_STALL = (MEM_LAT != 0);

    typedef enum logic [1:0] {
        S_RUN,
        S_LOADREG,
        S_MEMWAIT,
        S_HALTED
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_load_idx;
    logic [3:0]        w_load_idx_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_next;
    logic              r_mem_store;
    logic              w_mem_store_next;
    logic              r_mem_err;
    logic              w_mem_err_next;

    logic [2:0] w_opcode;
    logic [2:0] w_sub;
    logic       w_special;
    logic       w_cond;
    logic       w_active;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_lsh;
    logic       w_is_br;
    logic       w_inc;
    logic       w_shift;
    logic       w_halt;
    logic       w_regset;

    // Raw field decode; gating by state and validity happens in the FSM.
    assign w_opcode   = Instruction[IW-1:IW-3];
    assign w_sub      = Instruction[IW-4:IW-6];
    assign w_special  = ~|Instruction[IW-6:0];
    assign w_cond     = Instruction[IW-4];
    assign w_active   = instr_valid & ~Reset;
    assign w_is_load  = (w_opcode == OPC_LOAD);
    assign w_is_store = (w_opcode == OPC_STORE);
    assign w_is_lsh   = (w_opcode == OPC_LSH);
    assign w_is_br    = (w_opcode == OPC_BR);
    assign w_inc      = (w_opcode == OPC_CMP) & (w_sub == 3'b111);
    assign w_shift    = w_is_br & ~w_cond & w_special;
    assign w_halt     = w_is_br & w_cond & w_special;
    assign w_regset   = w_is_lsh & (w_sub == 3'b111);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_RUN;
            r_load_idx  <= 4'd0;
            r_wait_cnt  <= '0;
            r_mem_store <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_load_idx  <= w_load_idx_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_mem_store <= w_mem_store_next;
            r_mem_err   <= w_mem_err_next;
        end
    end

    always_comb begin
        Immediate        = 1'b0;
        RegSet           = 1'b0;
        BranchEn         = 1'b0;
        ConditionBranch  = 1'b0;
        Halt             = 1'b0;
        Shift            = 1'b0;
        RDX              = 1'b0;
        MemToReg         = 1'b0;
        RegWriteEn       = 1'b0;
        MemWriteEn       = 1'b0;
        Inc              = 1'b0;
        LoadWord         = 1'b0;
        Stall            = 1'b0;
        w_state_next     = r_state;
        w_load_idx_next  = r_load_idx;
        w_wait_cnt_next  = r_wait_cnt;
        w_mem_store_next = r_mem_store;
        w_mem_err_next   = r_mem_err;

        // Bubbles and reset freeze everything and silence all strobes.
        if (w_active) begin
            unique case (r_state)
                S_RUN: begin
                    Immediate       = w_is_lsh & (w_sub != 3'b110);
                    RDX             = w_is_lsh & (w_sub == 3'b110);
                    RegSet          = w_regset;
                    Inc             = w_inc;
                    ConditionBranch = w_cond;
                    BranchEn        = w_is_br & ~w_special;
                    Halt            = w_halt;
                    Shift           = w_shift;
                    MemToReg        = w_is_load;
                    MemWriteEn      = w_is_store;
                    RegWriteEn      = w_is_load | w_is_lsh | w_inc | w_shift
                                    | (w_opcode == OPC_ADD) | (w_opcode == OPC_SUB)
                                    | (w_opcode == OPC_XOR);
                    if (w_regset) begin
                        w_state_next    = S_LOADREG;
                        w_load_idx_next = 4'd0;
                    end else if (w_halt) begin
                        w_state_next = S_HALTED;
                    end else if (MEM_STALL && (w_is_load | w_is_store) && !mem_ready) begin
                        Stall            = 1'b1;
                        RegWriteEn       = 1'b0;
                        w_state_next     = S_MEMWAIT;
                        w_wait_cnt_next  = '0;
                        w_mem_store_next = w_is_store;
                    end
                end
                S_LOADREG: begin
                    LoadWord = 1'b1;
                    if (r_load_idx == LOAD_LAST) begin
                        w_state_next    = S_RUN;
                        w_load_idx_next = 4'd0;
                    end else begin
                        w_load_idx_next = r_load_idx + 4'd1;
                    end
                end
                S_MEMWAIT: begin
                    MemWriteEn = r_mem_store;
                    MemToReg   = ~r_mem_store;
                    if (mem_ready) begin
                        RegWriteEn   = ~r_mem_store;
                        w_state_next = S_RUN;
                    end else begin
                        Stall = 1'b1;
                        if (r_wait_cnt == WAIT_LAST) begin
                            w_mem_err_next = 1'b1;
                            w_state_next   = S_HALTED;
                        end else begin
                            w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                S_HALTED: begin
                    w_state_next = S_HALTED;
                end
                default: begin
                    w_state_next = S_RUN;
                end
            endcase
        end
    end

    assign LoadIdx = r_load_idx;
    assign Halted  = (r_state == S_HALTED);
    assign MemErr  = r_mem_err;

`ifdef CTRL_PERF_CNT_EN
    logic        w_retire;
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_stall;

    // An instruction retires when decoded in RUN without stalling, or when its memory wait completes.
    assign w_retire = w_active & (((r_state == S_RUN) & ~Stall)
                                | ((r_state == S_MEMWAIT) & mem_ready));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_perf_instr <= 32'd0;
            r_perf_stall <= 32'd0;
        end else if (r_state != S_HALTED) begin
            r_perf_instr <= r_perf_instr + 32'(w_retire);
            r_perf_stall <= r_perf_stall + 32'(Stall);
        end
    end

    assign perf_instr = r_perf_instr;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer (LOAD_WORDS=2, MEM_LAT=2, MEM_TIMEOUT=4):
// directed scenarios against hand-derived constants, then random traffic against a behavioural model.
module tb_ctrl_sequencer;

    localparam int unsigned LW = 2;
    localparam int unsigned ML = 2;
    localparam int unsigned MT = 4;

    logic       Clk;
    logic       Reset;
    logic [8:0] Instruction;
    logic       instr_valid;
    logic       mem_ready;
    logic       Immediate, RegSet, BranchEn, ConditionBranch, Halt, Shift, RDX;
    logic       MemToReg, RegWriteEn, MemWriteEn, Inc, LoadWord, Stall, Halted, MemErr;
    logic [3:0] LoadIdx;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_instr;
    logic [31:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    ctrl_sequencer #(.IW(9), .LOAD_WORDS(LW), .MEM_LAT(ML), .MEM_TIMEOUT(MT)) dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .Immediate(Immediate), .RegSet(RegSet), .BranchEn(BranchEn),
        .ConditionBranch(ConditionBranch), .Halt(Halt), .Shift(Shift), .RDX(RDX),
        .MemToReg(MemToReg), .RegWriteEn(RegWriteEn), .MemWriteEn(MemWriteEn), .Inc(Inc),
        .LoadWord(LoadWord), .LoadIdx(LoadIdx), .Stall(Stall), .Halted(Halted), .MemErr(MemErr)
`ifdef CTRL_PERF_CNT_EN
        , .perf_instr(perf_instr), .perf_stall(perf_stall)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Bit layout of obs: [18]Imm [17]RegSet [16]BranchEn [15]CondBr [14]Halt [13]Shift [12]RDX
    // [11]MemToReg [10]RegWriteEn [9]MemWriteEn [8]Inc [7]LoadWord [6:3]LoadIdx [2]Stall [1]Halted [0]MemErr
    logic [18:0] obs;
    assign obs = {Immediate, RegSet, BranchEn, ConditionBranch, Halt, Shift, RDX, MemToReg,
                  RegWriteEn, MemWriteEn, Inc, LoadWord, LoadIdx, Stall, Halted, MemErr};

    // Behavioural model: what the machine is doing, in spec terms.
    bit m_halted = 0;
    bit m_err = 0;
    int m_words_left = 0;
    int m_idx = 0;
    bit m_waiting = 0;
    int m_wait_n = 0;
    bit m_store = 0;

    function automatic logic [18:0] exp_out();
        logic [18:0] e;
        int op, sb;
        bit sp, cnd;
        e = '0;
        e[6:3] = 4'(m_idx);
        e[1] = m_halted;
        e[0] = m_err;
        op  = int'(Instruction) / 64;
        sb  = (int'(Instruction) / 8) % 8;
        sp  = (int'(Instruction) % 16) == 0;
        cnd = sb >= 4;
        if (!Reset && instr_valid && !m_halted) begin
            if (m_words_left > 0) begin
                e[7] = 1'b1;
            end else if (m_waiting) begin
                e[9]  = m_store;
                e[11] = !m_store;
                e[10] = mem_ready && !m_store;
                e[2]  = !mem_ready;
            end else begin
                e[18] = (op == 6) && (sb != 6);
                e[12] = (op == 6) && (sb == 6);
                e[17] = (op == 6) && (sb == 7);
                e[8]  = (op == 5) && (sb == 7);
                e[15] = cnd;
                e[16] = (op == 7) && !sp;
                e[14] = (op == 7) && cnd && sp;
                e[13] = (op == 7) && !cnd && sp;
                e[11] = (op == 0);
                e[9]  = (op == 1);
                e[10] = (op == 0) || (op == 2) || (op == 3) || (op == 4) || (op == 6) || e[8] || e[13];
                if (op <= 1 && !mem_ready) begin
                    e[2]  = 1'b1;
                    e[10] = 1'b0;
                end
            end
        end
        return e;
    endfunction

    task automatic model_step();
        int op, sb;
        bit sp, cnd;
        op  = int'(Instruction) / 64;
        sb  = (int'(Instruction) / 8) % 8;
        sp  = (int'(Instruction) % 16) == 0;
        cnd = sb >= 4;
        if (Reset) begin
            m_halted = 0; m_err = 0; m_words_left = 0; m_idx = 0; m_waiting = 0; m_wait_n = 0; m_store = 0;
        end else if (instr_valid && !m_halted) begin
            if (m_words_left > 0) begin
                m_words_left--;
                m_idx = (m_words_left == 0) ? 0 : m_idx + 1;
            end else if (m_waiting) begin
                if (mem_ready) begin
                    m_waiting = 0;
                end else begin
                    m_wait_n++;
                    if (m_wait_n >= int'(MT)) begin
                        m_waiting = 0;
                        m_halted  = 1;
                        m_err     = 1;
                    end
                end
            end else if (op == 6 && sb == 7) begin
                m_words_left = int'(LW);
                m_idx = 0;
            end else if (op == 7 && cnd && sp) begin
                m_halted = 1;
            end else if (op <= 1 && !mem_ready) begin
                m_waiting = 1;
                m_wait_n  = 0;
                m_store   = (op == 1);
            end
        end
    endtask

    task automatic apply(input logic [8:0] ins, input logic v, input logic r, input logic rdy);
        Instruction = ins;
        instr_valid = v;
        Reset       = r;
        mem_ready   = rdy;
        #3;
    endtask

    task automatic advance();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(9'h081, 1'b1, 1'b1, 1'b1);
            checks++;
            if ({obs[18:7], obs[2]} !== 13'd0) begin
                errors++;
                $display("FAIL reset_strobes cycle %0d: got %h expected strobes 0", i, obs);
            end
            if (i > 0) begin
                checks++;
                if (obs !== 19'h0) begin
                    errors++;
                    $display("FAIL reset_state cycle %0d: got %h expected 00000", i, obs);
                end
            end
            advance();
        end
    endtask

    task automatic test_decode();
        logic [8:0]  ins [7];
        logic        val [7];
        logic [18:0] exp [7];
        ins = '{9'h081, 9'h081, 9'h178, 9'h1C0, 9'h1C9, 9'h1B0, 9'h185};
        val = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp = '{19'h00400, 19'h00000, 19'h08500, 19'h02400, 19'h10000, 19'h09400, 19'h40400};
        for (int i = 0; i < 7; i++) begin
            apply(ins[i], val[i], 1'b0, 1'b1);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL decode step %0d instr %h: got %h expected %h", i, ins[i], obs, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_regset_load();
        logic [8:0]  ins [4];
        logic [18:0] exp [4];
        ins = '{9'h1B8, 9'h1FF, 9'h000, 9'h081};
        exp = '{19'h68400, 19'h00080, 19'h00088, 19'h00400};
        apply(9'h081, 1'b1, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL regset_load step %0d: got %h expected %h", i, obs, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        logic [8:0]  ins [4];
        logic        rdy [4];
        logic [18:0] exp [4];
        ins = '{9'h000, 9'h000, 9'h000, 9'h081};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{19'h00804, 19'h00804, 19'h00C00, 19'h00400};
        apply(9'h081, 1'b1, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], 1'b1, 1'b0, rdy[i]);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL mem_wait step %0d: got %h expected %h", i, obs, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_mem_timeout();
        logic [8:0]  ins [9];
        logic        rdy [9];
        logic        rst [9];
        logic [18:0] exp [9];
        ins = '{9'h040, 9'h040, 9'h040, 9'h040, 9'h040, 9'h081, 9'h081, 9'h081, 9'h081};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{19'h00204, 19'h00204, 19'h00204, 19'h00204, 19'h00204,
                19'h00003, 19'h00003, 19'h00003, 19'h00400};
        apply(9'h081, 1'b1, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < 9; i++) begin
            apply(ins[i], 1'b1, rst[i], rdy[i]);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL mem_timeout step %0d: got %h expected %h", i, obs, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_halt();
        logic [8:0]  ins [4];
        logic        rst [4];
        logic [18:0] exp [4];
        ins = '{9'h1E0, 9'h081, 9'h081, 9'h081};
        rst = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{19'h0C000, 19'h00002, 19'h00002, 19'h00400};
        apply(9'h081, 1'b1, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], 1'b1, rst[i], 1'b1);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL halt step %0d: got %h expected %h", i, obs, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_load();
        logic [8:0]  ins [4];
        logic        rst [4];
        logic [18:0] exp [4];
        ins = '{9'h1B8, 9'h1FF, 9'h000, 9'h081};
        rst = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp = '{19'h68400, 19'h00080, 19'h00008, 19'h00400};
        apply(9'h081, 1'b1, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < 4; i++) begin
            apply(ins[i], 1'b1, rst[i], 1'b1);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_mid_load step %0d: got %h expected %h", i, obs, exp[i]);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [8:0]  ins;
        logic [8:0]  templ [6];
        logic        v, r, rdy;
        logic [18:0] e;
        templ = '{9'h1B8, 9'h1E0, 9'h000, 9'h040, 9'h1C0, 9'h178};
        ins = 9'h081;
        apply(ins, 1'b1, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < 1500; i++) begin
            if (!m_waiting) begin
                if ($urandom_range(0, 9) < 4) ins = templ[$urandom_range(0, 5)];
                else ins = 9'($urandom);
            end
            v   = ($urandom_range(0, 99) < 85);
            rdy = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            apply(ins, v, r, rdy);
            e = exp_out();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random cycle %0d instr %h v%0b r%0b rdy%0b: got %h expected %h",
                         i, ins, v, r, rdy, obs, e);
            end
            advance();
        end
    endtask

    initial begin
        Instruction = 9'h0;
        instr_valid = 1'b0;
        Reset       = 1'b1;
        mem_ready   = 1'b0;
        @(posedge Clk);
        #1;
        test_reset();
        test_decode();
        test_regset_load();
        test_mem_wait();
        test_mem_timeout();
        test_halt();
        test_reset_mid_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
